// File: rtl/mux_nto1_rr.sv
// N-to-1 registered mux with valid/ready on every channel and on the output.
// Channel choice is either an explicit sel (fixed mode) or a fair round-robin scan.
module mux_nto1_rr #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_valid,
    output logic [N_CH-1:0]       in_ready,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_ch,
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] gnt;
    logic             gnt_vld;
    logic [WIDTH-1:0] gnt_data;
    logic             load_en;

    assign load_en = !out_valid || out_ready;

    // Round-robin scans ptr..N_CH-1 first, then wraps to 0..ptr-1.
    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        if (!mode) begin
            for (int k = 0; k < N_CH; k++) begin
                if (sel == SEL_W'(k) && in_valid[k]) begin
                    gnt     = SEL_W'(k);
                    gnt_vld = 1'b1;
                end
            end
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (!gnt_vld && SEL_W'(k) >= ptr && in_valid[k]) begin
                    gnt     = SEL_W'(k);
                    gnt_vld = 1'b1;
                end
            end
            for (int k = 0; k < N_CH; k++) begin
                if (!gnt_vld && SEL_W'(k) < ptr && in_valid[k]) begin
                    gnt     = SEL_W'(k);
                    gnt_vld = 1'b1;
                end
            end
        end
    end

    always_comb begin
        gnt_data = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (gnt == SEL_W'(k)) gnt_data = in_data[k*WIDTH +: WIDTH];
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_rdy
        assign in_ready[k] = rst_n && load_en && gnt_vld && (gnt == SEL_W'(k));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            ptr       <= '0;
        end else if (load_en) begin
            if (gnt_vld) begin
                out_data  <= gnt_data;
                out_ch    <= gnt;
                out_valid <= 1'b1;
                // Explicit wrap keeps ptr in range for non-power-of-two N_CH.
                if (mode) ptr <= (gnt == SEL_W'(N_CH - 1)) ? '0 : gnt + SEL_W'(1);
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_nto1_rr.sv
// Bench for mux_nto1_rr: table vectors, corner-case sequences and a randomized
// run against a queue-free behavioural model of the slot and round-robin pointer.
module tb_mux_nto1_rr;
    localparam int N  = 4;
    localparam int W  = 4;
    localparam int SW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [N*W-1:0] in_data;
    logic [N-1:0]  in_valid, in_ready;
    logic          mode;
    logic [SW-1:0] sel;
    logic [W-1:0]  out_data;
    logic [SW-1:0] out_ch;
    logic          out_valid, out_ready;

    mux_nto1_rr #(.N_CH(N), .WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
        .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
    );

    // Three-channel instance for out-of-range sel and pointer wrap.
    logic        r3_n, m3, ov3, or3;
    logic [11:0] d3;
    logic [2:0]  v3, rdy3;
    logic [1:0]  s3, oc3;
    logic [3:0]  od3;

    mux_nto1_rr #(.N_CH(3), .WIDTH(4)) dut3 (
        .clk(clk), .rst_n(r3_n), .in_data(d3), .in_valid(v3),
        .in_ready(rdy3), .mode(m3), .sel(s3), .out_data(od3),
        .out_ch(oc3), .out_valid(ov3), .out_ready(or3)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Reference model: one slot plus a pointer, grants from the scan rule.
    bit m_valid = 1'b0;
    int m_data = 0, m_ch = 0, m_ptr = 0;

    function automatic int chan(input int k);
        return int'(in_data[k*W +: W]);
    endfunction

    function automatic int mgrant();
        if (!mode) return (int'(sel) < N && in_valid[sel]) ? int'(sel) : -1;
        for (int o = 0; o < N; o++) begin
            int k;
            k = (m_ptr + o) % N;
            if (in_valid[k]) return k;
        end
        return -1;
    endfunction

    task automatic step();
        int g;
        bit le;
        logic [N-1:0] er;
        @(negedge clk);
        g  = mgrant();
        le = !m_valid || out_ready;
        er = '0;
        if (rst_n && le && g >= 0) er[g] = 1'b1;
        chk("in_ready", in_ready, er);
        @(posedge clk);
        #1;
        if (!rst_n) begin
            m_valid = 1'b0; m_data = 0; m_ch = 0; m_ptr = 0;
        end else if (le) begin
            if (g >= 0) begin
                m_data = chan(g); m_ch = g; m_valid = 1'b1;
                if (mode) m_ptr = (g + 1) % N;
            end else begin
                m_valid = 1'b0;
            end
        end
        chk("out_valid", out_valid, m_valid);
        chk("out_data", out_data, m_data);
        chk("out_ch", out_ch, m_ch);
    endtask

    task automatic tick3();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       md;
        logic [1:0] s;
        logic [3:0] v;
        logic       ordy;
        logic [3:0] ed;
        logic [1:0] ec;
        logic       ev;
    } vec_t;

    vec_t tbl[6];

    initial begin
        tbl[0] = '{1'b0, 2'd0, 4'hF,    1'b1, 4'd8, 2'd0, 1'b1};
        tbl[1] = '{1'b0, 2'd1, 4'hF,    1'b1, 4'd4, 2'd1, 1'b1};
        tbl[2] = '{1'b0, 2'd2, 4'hF,    1'b1, 4'd2, 2'd2, 1'b1};
        tbl[3] = '{1'b0, 2'd3, 4'hF,    1'b1, 4'd1, 2'd3, 1'b1};
        tbl[4] = '{1'b0, 2'd1, 4'b1101, 1'b1, 4'd1, 2'd3, 1'b0};
        tbl[5] = '{1'b0, 2'd0, 4'b0001, 1'b1, 4'd8, 2'd0, 1'b1};

        rst_n = 1'b0; mode = 1'b0; sel = '0; in_valid = '0; out_ready = 1'b1;
        in_data = {4'd1, 4'd2, 4'd4, 4'd8};
        r3_n = 1'b0; m3 = 1'b0; s3 = '0; v3 = '0; or3 = 1'b1; d3 = '0;

        // Reset state
        step();
        step();
        chk("rst_valid", out_valid, 0);
        chk("rst_ch", out_ch, 0);
        rst_n = 1'b1;

        // Fixed-mode table
        for (int i = 0; i < 6; i++) begin
            mode = tbl[i].md; sel = tbl[i].s; in_valid = tbl[i].v; out_ready = tbl[i].ordy;
            step();
            chk("tbl_data", out_data, tbl[i].ed);
            chk("tbl_ch", out_ch, tbl[i].ec);
            chk("tbl_valid", out_valid, tbl[i].ev);
        end

        // Round-robin, all valid: 0,1,2,3,0,1,2,3 with one-hot ready
        mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("rr_onehot", $countones(in_ready), 1);
            step();
            chk("rr_seq", out_ch, i % 4);
        end

        // Round-robin, channels 1 and 3 only
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_skip", in_ready & 4'b0101, 0);
            step();
            chk("rr13", out_ch, (i % 2) ? 3 : 1);
        end

        // Back-pressure: hold channel 2's word, then drain and load together
        mode = 1'b0; sel = 2'd2; in_valid = 4'hF; out_ready = 1'b1;
        step();
        chk("bp_load", out_ch, 2);
        out_ready = 1'b0;
        in_data[2*W +: W] = 4'd7;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold_data", out_data, 2);
            chk("bp_hold_ch", out_ch, 2);
            chk("bp_hold_rdy", in_ready, 0);
        end
        out_ready = 1'b1;
        step();
        chk("bp_release", out_data, 7);
        chk("bp_rel_valid", out_valid, 1);
        in_data = {4'd1, 4'd2, 4'd4, 4'd8};

        // Reset while holding a word with a nonzero pointer
        mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
        step();
        step();
        out_ready = 1'b0;
        rst_n = 1'b0;
        step();
        chk("mrst_valid", out_valid, 0);
        chk("mrst_data", out_data, 0);
        chk("mrst_ch", out_ch, 0);
        chk("mrst_rdy", in_ready, 0);
        rst_n = 1'b1; out_ready = 1'b1;
        step();
        chk("post_rst_ch", out_ch, 0);

        // Randomized run against the model
        for (int i = 0; i < 400; i++) begin
            mode      = 1'($urandom);
            sel       = SW'($urandom);
            in_valid  = N'($urandom);
            out_ready = ($urandom % 4) != 0;
            in_data   = (N*W)'($urandom);
            rst_n     = ($urandom % 50) != 0;
            step();
        end
        rst_n = 1'b1;

        // Three channels: out-of-range sel, then pointer wrap 2 -> 0
        d3 = {4'd3, 4'd2, 4'd1};
        tick3();
        chk("n3_rst", ov3, 0);
        r3_n = 1'b1; v3 = 3'b111;
        tick3();
        chk("n3_load", od3, 1);
        chk("n3_valid", ov3, 1);
        s3 = 2'd3;
        #1;
        chk("n3_oor_rdy", rdy3, 0);
        tick3();
        chk("n3_oor_valid", ov3, 0);
        chk("n3_oor_hold", od3, 1);
        m3 = 1'b1; v3 = 3'b010;
        tick3();
        chk("n3_rr1", oc3, 1);
        v3 = 3'b100;
        tick3();
        chk("n3_rr2", oc3, 2);
        v3 = 3'b111;
        tick3();
        chk("n3_wrap", oc3, 0);
        chk("n3_wrap_data", od3, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
